s526_param_seq: RTL and testbench
=================================

S526_PARAM_SEQ -- requirements
Module: s526_param_seq

Interface
REQ-001 SHALL have parameter NUM_PH, default 4, meaning number of phases (legal 2..8).
REQ-002 SHALL have parameter CNT_W, default 8, meaning phase-duration counter width.
REQ-003 SHALL have parameter CYC_W, default 8, meaning completed-cycle counter width.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  meaning asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port G0  in  1  meaning synchronous clear.
REQ-007 SHALL have port G1  in  1  meaning start request.
REQ-008 SHALL have port G2  in  1  meaning pause/hold.
REQ-009 SHALL have port dur_i  in  CNT_W  meaning current phase duration minus one, sampled in LOAD.
REQ-010 SHALL have port phase_o  out  NUM_PH  meaning one-hot active phase; all zero in IDLE.
REQ-011 SHALL have port cnt_o  out  CNT_W  meaning remaining-count register.
REQ-012 SHALL have port tick_o  out  1  meaning one-cycle pulse on a phase advance.
REQ-013 SHALL have port cyc_o  out  CYC_W  meaning completed full sequences, saturating.
REQ-014 SHALL have port busy_o  out  1  meaning state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, PAUSE; all outputs registered.
REQ-016 G0=1 SHALL take priority in any state: next cycle IDLE, phase index 0, cnt_o 0, tick_o 0; cyc_o unchanged.
REQ-017 IDLE with G1=1 SHALL go to LOAD; G1 is ignored in all other states.
REQ-018 LOAD SHALL load cnt_o <= dur_i and go to RUN; LOAD lasts exactly one cycle.
REQ-019 RUN with G2=1 SHALL go to PAUSE with cnt_o frozen; G2 overrides cnt_o==0 in the same cycle.
REQ-020 RUN with G2=0 and cnt_o!=0 SHALL decrement cnt_o by 1.
REQ-021 RUN with G2=0 and cnt_o==0 SHALL advance the phase index, go to LOAD and assert tick_o for the following cycle only.
REQ-022 Phase dwell SHALL be 1 LOAD cycle plus dur_i+1 RUN cycles; dur_i=0 gives a 1-cycle RUN.
REQ-023 Index NUM_PH-1 SHALL wrap to 0; each wrap SHALL increment cyc_o, which saturates at all-ones.
REQ-024 PAUSE with G2=0 SHALL return to RUN at the frozen count; PAUSE with G2=1 SHALL stay in PAUSE.
REQ-025 phase_o SHALL equal one-hot(index) in LOAD, RUN and PAUSE; busy_o SHALL be 1 in those states.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, index 0, phase_o 0, cnt_o 0, tick_o 0, cyc_o 0, busy_o 0, regardless of clk.
REQ-027 Reset asserted mid-phase SHALL abandon the phase; after release the block SHALL wait in IDLE for G1.

Configuration
REQ-028 Macro S526_LOCK_KEY_EN SHALL add parameter KEY_W (default 16), parameter KEY (default 16'hA5C3) and input key_i [KEY_W-1:0].
REQ-029 With S526_LOCK_KEY_EN defined and key_i==KEY, behaviour SHALL be identical to the unlocked build.
REQ-030 With S526_LOCK_KEY_EN defined and key_i!=KEY, the index SHALL advance by 2 modulo NUM_PH and tick_o SHALL stay 0.
REQ-031 Without S526_LOCK_KEY_EN, key_i and the key logic SHALL be absent.

Verification (NUM_PH=4, CNT_W=8, CYC_W=8)
REQ-032 Drive reset=0 mid-RUN without a clock edge -> all outputs 0 at once; stays IDLE after release until G1.
REQ-033 G1 pulse, dur_i=3 -> LOAD with phase_o=0001, RUN cnt_o 3,2,1,0, then tick_o=1 with phase_o=0010.
REQ-034 dur_i=0 held, G1 pulse -> phase_o 0001,0010,0100,1000,0001 every 2 cycles; cyc_o steps 0->1 at the wrap.
REQ-035 G2=1 for 5 cycles with cnt_o=2 in RUN -> PAUSE, cnt_o held at 2, busy_o=1; after release cnt_o 1,0 and advance.
REQ-036 G0=1 in the same cycle as G2=1 in RUN -> IDLE, phase_o 0000, cyc_o unchanged; G0 and G1 together in IDLE -> stays IDLE.
REQ-037 Lock build, key_i=16'h0000, dur_i=0 -> phase_o 0001,0100,0001, tick_o never 1; with key_i=16'hA5C3, sequence matches REQ-034.

Source files
------------

// File: rtl/s526_param_seq.sv
// s526_param_seq: multi-phase sequencer with LOAD/RUN/PAUSE dwell control.
// Each phase takes one LOAD cycle followed by dur_i+1 RUN cycles. Completed
// full sequences are counted in cyc_o, which saturates at all-ones.
// Optional build macro: S526_LOCK_KEY_EN adds a key input. While the key is
// wrong, each phase advance skips one phase and suppresses tick_o.
module s526_param_seq #(
   parameter int NUM_PH = 4,
   parameter int CNT_W  = 8,
   parameter int CYC_W  = 8
`ifdef S526_LOCK_KEY_EN
   ,
   parameter int               KEY_W = 16,
   parameter logic [KEY_W-1:0] KEY   = 16'hA5C3
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              G0,
   input  logic              G1,
   input  logic              G2,
   input  logic [CNT_W-1:0]  dur_i,
`ifdef S526_LOCK_KEY_EN
   input  logic [KEY_W-1:0]  key_i,
`endif
   output logic [NUM_PH-1:0] phase_o,
   output logic [CNT_W-1:0]  cnt_o,
   output logic              tick_o,
   output logic [CYC_W-1:0]  cyc_o,
   output logic              busy_o
);

   localparam int             IDX_W  = (NUM_PH > 1) ? $clog2(NUM_PH) : 1;
   localparam logic [IDX_W:0] PH_LIM = (IDX_W+1)'(NUM_PH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSE} state_t;

   state_t            r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_idx, w_idx_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_tick, w_tick_nxt;
   logic [CYC_W-1:0]  r_cyc, w_cyc_nxt;
   logic [NUM_PH-1:0] r_phase, w_phase_nxt;
   logic              r_busy, w_busy_nxt;

   logic [IDX_W:0]    w_step;
   logic [IDX_W:0]    w_idx_sum;
   logic              w_wrap;
   logic [IDX_W-1:0]  w_idx_adv;
   logic              w_adv_tick;
   logic [CYC_W-1:0]  w_cyc_inc;

`ifdef S526_LOCK_KEY_EN
   logic              w_key_ok;
   assign w_key_ok   = (key_i == KEY);
   // A wrong key makes each advance skip one phase and hides the tick.
   assign w_step     = w_key_ok ? (IDX_W+1)'(1) : (IDX_W+1)'(2);
   assign w_adv_tick = w_key_ok;
`else
   assign w_step     = (IDX_W+1)'(1);
   assign w_adv_tick = 1'b1;
`endif

   // Modulo-NUM_PH index advance; the sum is one bit wider to catch the wrap.
   assign w_idx_sum = {1'b0, r_idx} + w_step;
   assign w_wrap    = (w_idx_sum >= PH_LIM);
   assign w_idx_adv = w_wrap ? IDX_W'(w_idx_sum - PH_LIM) : IDX_W'(w_idx_sum);
   assign w_cyc_inc = (&r_cyc) ? r_cyc : r_cyc + CYC_W'(1);

   // Next-state and next-output logic; G0 clear overrides every state.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_tick_nxt  = 1'b0;
      w_cyc_nxt   = r_cyc;
      if (G0) begin
         w_state_nxt = S_IDLE;
         w_idx_nxt   = '0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (G1) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
               w_cnt_nxt   = dur_i;
               w_state_nxt = S_RUN;
            end
            S_RUN: begin
               if (G2) begin
                  w_state_nxt = S_PAUSE;
               end else if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end else begin
                  w_idx_nxt   = w_idx_adv;
                  w_tick_nxt  = w_adv_tick;
                  w_state_nxt = S_LOAD;
                  if (w_wrap) w_cyc_nxt = w_cyc_inc;
               end
            end
            S_PAUSE: begin
               if (!G2) w_state_nxt = S_RUN;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
      w_busy_nxt  = (w_state_nxt != S_IDLE);
      w_phase_nxt = w_busy_nxt ? (NUM_PH'(1) << w_idx_nxt) : '0;
   end

   // State and registered outputs; reset abandons any phase in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_tick  <= 1'b0;
         r_cyc   <= '0;
         r_phase <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tick  <= w_tick_nxt;
         r_cyc   <= w_cyc_nxt;
         r_phase <= w_phase_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign phase_o = r_phase;
   assign cnt_o   = r_cnt;
   assign tick_o  = r_tick;
   assign cyc_o   = r_cyc;
   assign busy_o  = r_busy;

endmodule

// File: tb/tb_s526_param_seq.sv
// Testbench for s526_param_seq (NUM_PH=4, CNT_W=8, CYC_W=8).
// Directed scenarios plus a randomized run against a behavioural model.
module tb_s526_param_seq;

   logic       clk;
   logic       reset;
   logic       G0, G1, G2;
   logic [7:0] dur;
   logic [3:0] phase_o;
   logic [7:0] cnt_o;
   logic       tick_o;
   logic [7:0] cyc_o;
   logic       busy_o;
`ifdef S526_LOCK_KEY_EN
   logic [15:0] key;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   s526_param_seq #(.NUM_PH(4), .CNT_W(8), .CYC_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .G0      (G0),
      .G1      (G1),
      .G2      (G2),
      .dur_i   (dur),
`ifdef S526_LOCK_KEY_EN
      .key_i   (key),
`endif
      .phase_o (phase_o),
      .cnt_o   (cnt_o),
      .tick_o  (tick_o),
      .cyc_o   (cyc_o),
      .busy_o  (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: activity flags, phase number, remaining count.
   bit       m_active;   // sequence in progress
   bit       m_loading;  // in the one-cycle load slot
   bit       m_held;     // paused
   int       m_idx;
   int       m_cnt;
   int       m_cyc;
   bit       m_tick;
   logic [3:0] m_phase;

   function automatic bit key_good();
`ifdef S526_LOCK_KEY_EN
      return key == 16'hA5C3;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      m_active = 0; m_loading = 0; m_held = 0;
      m_idx = 0; m_cnt = 0; m_cyc = 0; m_tick = 0; m_phase = 4'b0000;
   endtask

   task automatic model_step();
      m_tick = 0;
      if (G0) begin
         m_active = 0; m_loading = 0; m_held = 0; m_idx = 0; m_cnt = 0;
      end else if (!m_active) begin
         if (G1) begin m_active = 1; m_loading = 1; end
      end else if (m_loading) begin
         m_cnt = dur; m_loading = 0;
      end else if (m_held) begin
         if (!G2) m_held = 0;
      end else if (G2) begin
         m_held = 1;
      end else if (m_cnt > 0) begin
         m_cnt = m_cnt - 1;
      end else begin
         m_idx = m_idx + (key_good() ? 1 : 2);
         if (m_idx >= 4) begin
            m_idx = m_idx - 4;
            if (m_cyc < 255) m_cyc = m_cyc + 1;
         end
         m_tick = key_good();
         m_loading = 1;
      end
      m_phase = m_active ? 4'(1 << m_idx) : 4'b0000;
   endtask

   task automatic clk_step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      G0 = 0; G1 = 0; G2 = 0;
      reset = 1'b0;
      model_reset();
      #2;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      dur = 8'd5;
      G1 = 1; clk_step(); G1 = 0;
      clk_step(); clk_step(); clk_step();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      n_cmp++; if (phase_o !== 4'b0000) begin n_bad++; $display("FAIL reset_phase got=%b exp=0000", phase_o); end
      n_cmp++; if (cnt_o !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
      n_cmp++; if (tick_o !== 1'b0) begin n_bad++; $display("FAIL reset_tick got=%b exp=0", tick_o); end
      n_cmp++; if (cyc_o !== 8'd0) begin n_bad++; $display("FAIL reset_cyc got=%0d exp=0", cyc_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         clk_step();
         n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_wait_idle cyc=%0d got=%b exp=0", i, busy_o); end
      end
      G1 = 1; clk_step(); G1 = 0;
      n_cmp++; if (phase_o !== 4'b0001 || busy_o !== 1'b1) begin
         n_bad++; $display("FAIL reset_restart got=%b/%b exp=0001/1", phase_o, busy_o);
      end
   endtask

   task automatic test_dur3();
      logic [7:0] exp_cnt [4];
      exp_cnt = '{8'd3, 8'd2, 8'd1, 8'd0};
      do_reset();
      dur = 8'd3;
      G1 = 1; clk_step(); G1 = 0;
      n_cmp++; if (phase_o !== 4'b0001 || busy_o !== 1'b1) begin
         n_bad++; $display("FAIL dur3_load got=%b/%b exp=0001/1", phase_o, busy_o);
      end
      for (int i = 0; i < 4; i++) begin
         clk_step();
         n_cmp++; if (cnt_o !== exp_cnt[i] || tick_o !== 1'b0) begin
            n_bad++; $display("FAIL dur3_run i=%0d cnt got=%0d exp=%0d tick=%b", i, cnt_o, exp_cnt[i], tick_o);
         end
      end
      clk_step();
      n_cmp++; if (tick_o !== 1'b1 || phase_o !== 4'b0010) begin
         n_bad++; $display("FAIL dur3_advance tick/phase got=%b/%b exp=1/0010", tick_o, phase_o);
      end
      clk_step();
      n_cmp++; if (tick_o !== 1'b0) begin n_bad++; $display("FAIL dur3_tick_pulse got=%b exp=0", tick_o); end
   endtask

   task automatic test_dur0_wrap();
      logic [3:0] exp_ph [5];
      exp_ph = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      dur = 8'd0;
      G1 = 1; clk_step(); G1 = 0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin clk_step(); clk_step(); end
         n_cmp++; if (phase_o !== exp_ph[i]) begin
            n_bad++; $display("FAIL dur0_phase i=%0d got=%b exp=%b", i, phase_o, exp_ph[i]);
         end
         n_cmp++; if (cyc_o !== ((i == 4) ? 8'd1 : 8'd0)) begin
            n_bad++; $display("FAIL dur0_cyc i=%0d got=%0d exp=%0d", i, cyc_o, (i == 4) ? 1 : 0);
         end
      end
   endtask

   task automatic test_pause();
      do_reset();
      dur = 8'd4;
      G1 = 1; clk_step(); G1 = 0;
      clk_step(); clk_step(); clk_step();
      n_cmp++; if (cnt_o !== 8'd2) begin n_bad++; $display("FAIL pause_pre cnt got=%0d exp=2", cnt_o); end
      G2 = 1;
      for (int i = 0; i < 5; i++) begin
         clk_step();
         n_cmp++; if (cnt_o !== 8'd2 || busy_o !== 1'b1 || phase_o !== 4'b0001) begin
            n_bad++; $display("FAIL pause_hold i=%0d cnt/busy/phase got=%0d/%b/%b exp=2/1/0001", i, cnt_o, busy_o, phase_o);
         end
      end
      G2 = 0;
      for (int i = 0; i < 3; i++) begin
         clk_step();
         n_cmp++; if (cnt_o !== 8'(2 - i) || tick_o !== 1'b0) begin
            n_bad++; $display("FAIL pause_resume i=%0d cnt got=%0d exp=%0d", i, cnt_o, 2 - i);
         end
      end
      clk_step();
      n_cmp++; if (tick_o !== 1'b1 || phase_o !== 4'b0010) begin
         n_bad++; $display("FAIL pause_advance tick/phase got=%b/%b exp=1/0010", tick_o, phase_o);
      end
   endtask

   task automatic test_clear();
      do_reset();
      dur = 8'd0;
      G1 = 1; clk_step(); G1 = 0;
      for (int i = 0; i < 8; i++) clk_step();
      dur = 8'd3;
      clk_step();
      n_cmp++; if (cnt_o !== 8'd3 || cyc_o !== 8'd1) begin
         n_bad++; $display("FAIL clear_pre cnt/cyc got=%0d/%0d exp=3/1", cnt_o, cyc_o);
      end
      G0 = 1; G2 = 1; clk_step(); G2 = 0;
      n_cmp++; if (phase_o !== 4'b0000 || busy_o !== 1'b0 || cnt_o !== 8'd0 || tick_o !== 1'b0) begin
         n_bad++; $display("FAIL clear_idle phase/busy/cnt/tick got=%b/%b/%0d/%b exp=0000/0/0/0", phase_o, busy_o, cnt_o, tick_o);
      end
      n_cmp++; if (cyc_o !== 8'd1) begin n_bad++; $display("FAIL clear_cyc got=%0d exp=1", cyc_o); end
      G1 = 1; clk_step(); G1 = 0; G0 = 0;
      n_cmp++; if (busy_o !== 1'b0 || phase_o !== 4'b0000) begin
         n_bad++; $display("FAIL clear_g0g1 busy/phase got=%b/%b exp=0/0000", busy_o, phase_o);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      dur = 8'd0;
      G1 = 1; clk_step(); G1 = 0;
      for (int i = 0; i < 260 * 8; i++) clk_step();
      n_cmp++; if (cyc_o !== 8'hFF) begin n_bad++; $display("FAIL saturate_cyc got=%0d exp=255", cyc_o); end
   endtask

`ifdef S526_LOCK_KEY_EN
   task automatic test_lock();
      logic [3:0] exp_ph [3];
      exp_ph = '{4'b0001, 4'b0100, 4'b0001};
      do_reset();
      key = 16'h0000;
      dur = 8'd0;
      G1 = 1; clk_step(); G1 = 0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            clk_step();
            n_cmp++; if (tick_o !== 1'b0) begin n_bad++; $display("FAIL lock_tick_run got=%b exp=0", tick_o); end
            clk_step();
         end
         n_cmp++; if (phase_o !== exp_ph[i] || tick_o !== 1'b0) begin
            n_bad++; $display("FAIL lock_bad_key i=%0d phase/tick got=%b/%b exp=%b/0", i, phase_o, tick_o, exp_ph[i]);
         end
      end
      do_reset();
      key = 16'hA5C3;
      G1 = 1; clk_step(); G1 = 0;
      clk_step(); clk_step();
      n_cmp++; if (phase_o !== 4'b0010 || tick_o !== 1'b1) begin
         n_bad++; $display("FAIL lock_good_key phase/tick got=%b/%b exp=0010/1", phase_o, tick_o);
      end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 800; i++) begin
         G0  = ($urandom_range(0, 31) == 0);
         G1  = ($urandom_range(0, 3) == 0);
         G2  = ($urandom_range(0, 3) == 0);
         dur = 8'($urandom_range(0, 3));
`ifdef S526_LOCK_KEY_EN
         key = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hA5C3;
`endif
         clk_step();
         n_cmp++; if (phase_o !== m_phase) begin n_bad++; $display("FAIL rand_phase i=%0d got=%b exp=%b", i, phase_o, m_phase); end
         n_cmp++; if (cnt_o !== 8'(m_cnt)) begin n_bad++; $display("FAIL rand_cnt i=%0d got=%0d exp=%0d", i, cnt_o, m_cnt); end
         n_cmp++; if (tick_o !== m_tick) begin n_bad++; $display("FAIL rand_tick i=%0d got=%b exp=%b", i, tick_o, m_tick); end
         n_cmp++; if (cyc_o !== 8'(m_cyc)) begin n_bad++; $display("FAIL rand_cyc i=%0d got=%0d exp=%0d", i, cyc_o, m_cyc); end
         n_cmp++; if (busy_o !== m_active) begin n_bad++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, busy_o, m_active); end
      end
      G0 = 0; G1 = 0; G2 = 0;
   endtask

   initial begin
      reset = 1'b1; G0 = 0; G1 = 0; G2 = 0; dur = 8'd0;
`ifdef S526_LOCK_KEY_EN
      key = 16'hA5C3;
`endif
      model_reset();
      test_reset();
      test_dur3();
      test_dur0_wrap();
      test_pause();
      test_clear();
      test_saturate();
`ifdef S526_LOCK_KEY_EN
      test_lock();
      key = 16'hA5C3;
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
